mmcm_drp_reconfig: RTL and testbench



---
 rtl/mmcm_drp_reconfig.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_reconfig.sv
// ---------------------------------------------------------------------------
// mmcm_drp_reconfig
// Runtime reconfiguration controller for a 7-series MMCME2. On request it
// holds the MMCM in reset, rewrites the feedback multiplier (CLKFBOUT) and
// the CLKOUT0..CLKOUT(N_CH-1) dividers through DRP read-modify-write cycles,
// releases reset and waits for lock. After power-up it runs only the reset
// and lock part of that sequence. Timeouts guard every DRP handshake and lock.
//
// Ports
//   clk_i       DRP clock, all logic on its rising edge
//   rst_i       asynchronous active-high reset
//   req_i       start reconfiguration (sampled only while idle)
//   mult_i      CLKFBOUT multiply value, 1..126
//   div_i       per-channel divide values, channel n at [7n+6:7n], 1..126
//   busy_o      controller active, req_i ignored
//   done_o      one-cycle pulse at the end of a request or power-up
//   err_o       last sequence failed, held until the next accepted request
//   daddr_o     DRP address
//   di_o        DRP write data
//   dout_i      DRP read data
//   den_o       DRP enable, one cycle per access
//   dwe_o       DRP write enable, qualified by den_o
//   drdy_i      DRP access complete
//   mmcm_rst_o  drives MMCM RST
//   locked_i    MMCM LOCKED
// ---------------------------------------------------------------------------
module mmcm_drp_reconfig #(
   parameter int N_CH         = 1,
   parameter int RST_HOLD     = 4,
   parameter int DRP_TIMEOUT  = 255,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic [6:0]          mult_i,
   input  logic [7*N_CH-1:0]   div_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [6:0]          daddr_o,
   output logic [15:0]         di_o,
   input  logic [15:0]         dout_i,
   output logic                den_o,
   output logic                dwe_o,
   input  logic                drdy_i,
   output logic                mmcm_rst_o,
   input  logic                locked_i
);

   typedef enum logic [3:0] {
      S_HOLD, S_RELEASE, S_WAIT_LOCK, S_DONE, S_IDLE, S_CHECK, S_PRE,
      S_RD, S_RD_W, S_WR1, S_WR1_W, S_WR2, S_WR2_W, S_POST
   } state_t;

   // A shared 16-bit saturating counter times every wait; it is cleared on
   // each state change, so a wait lasting N cycles ends when it reads N-1.
   localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
   localparam logic [15:0] DRP_LAST  = 16'(DRP_TIMEOUT - 1);
   localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [2:0]  LAST_SET  = 3'(N_CH);

   state_t              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [2:0]          set_q, set_d;       // 0 = feedback, n = CLKOUT(n-1)
   logic [6:0]          mult_q, mult_d;
   logic [7*N_CH-1:0]   div_q, div_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [6:0]          daddr_q, daddr_d;
   logic [15:0]         di_q, di_d;
   logic                den_q, den_d;
   logic                dwe_q, dwe_d;
   logic                mmcm_rst_q, mmcm_rst_d;

   // Value per register set; unused slots hold a harmless legal value so
   // the array always spans the full 3-bit set index.
   logic [6:0]          set_val [0:7];
   logic [6:0]          ch_bad;
   logic                any_bad;
   logic [6:0]          cur_val;
   logic                dout_unused;

   assign set_val[0] = mult_q;

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_set
         if (gi < N_CH) begin : g_used
            assign set_val[gi+1] = div_q[7*gi +: 7];
            assign ch_bad[gi]    = (div_q[7*gi +: 7] == 7'd0) ||
                                   (div_q[7*gi +: 7] == 7'd127);
         end else begin : g_unused
            assign set_val[gi+1] = 7'd1;
            assign ch_bad[gi]    = 1'b0;
         end
      end
   endgenerate

   assign any_bad     = (mult_q == 7'd0) || (mult_q == 7'd127) || (|ch_bad);
   assign cur_val     = set_val[set_q];
   // Only the top nibble of the read-back word is preserved.
   assign dout_unused = ^dout_i[11:0];

   // reg1 address of each register set; reg2 is always reg1 + 1.
   function automatic logic [6:0] reg1_addr(input logic [2:0] s);
      logic [6:0] a;
      case (s)
         3'd0:    a = 7'h14;
         3'd1:    a = 7'h08;
         3'd2:    a = 7'h0A;
         3'd3:    a = 7'h0C;
         3'd4:    a = 7'h0E;
         3'd5:    a = 7'h10;
         3'd6:    a = 7'h06;
         default: a = 7'h12;
      endcase
      return a;
   endfunction

   // reg1: preserved top nibble, high time, low time (low takes the odd cycle).
   function automatic logic [15:0] reg1_word(input logic [6:0] d,
                                             input logic [3:0] keep);
      logic [6:0] hi;
      logic [6:0] lo;
      hi = {1'b0, d[6:1]};
      lo = d - hi;
      return {keep, hi[5:0], lo[5:0]};
   endfunction

   // reg2: edge and no_count; phase and fractional fields forced to zero.
   function automatic logic [15:0] reg2_word(input logic [6:0] d);
      return {8'h00, d[0], (d == 7'd1), 6'h00};
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_HOLD;
         cnt_q      <= '0;
         set_q      <= '0;
         mult_q     <= '0;
         div_q      <= '0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         daddr_q    <= '0;
         di_q       <= '0;
         den_q      <= 1'b0;
         dwe_q      <= 1'b0;
         mmcm_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         set_q      <= set_d;
         mult_q     <= mult_d;
         div_q      <= div_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         daddr_q    <= daddr_d;
         di_q       <= di_d;
         den_q      <= den_d;
         dwe_q      <= dwe_d;
         mmcm_rst_q <= mmcm_rst_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      set_d      = set_q;
      mult_d     = mult_q;
      div_d      = div_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      daddr_d    = daddr_q;
      di_d       = di_q;
      den_d      = 1'b0;
      dwe_d      = 1'b0;
      mmcm_rst_d = mmcm_rst_q;

      case (state_q)
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d    = S_RELEASE;
               mmcm_rst_d = 1'b0;
            end
         end
         S_RELEASE: state_d = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (locked_i) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (cnt_q == LOCK_LAST) begin
               // MMCM reset is left released; it may still lock later.
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         S_IDLE: begin
            // A request coinciding with the done pulse is dropped.
            if (req_i && !done_q) begin
               state_d = S_CHECK;
               mult_d  = mult_i;
               div_d   = div_i;
               busy_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         S_CHECK: begin
            if (any_bad) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d    = S_PRE;
               mmcm_rst_d = 1'b1;
               set_d      = '0;
            end
         end
         S_PRE: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_RD;
               den_d   = 1'b1;
               daddr_d = reg1_addr(set_q);
            end
         end
         S_RD:  state_d = S_RD_W;
         S_WR1: state_d = S_WR1_W;
         S_WR2: state_d = S_WR2_W;
         S_RD_W: begin
            if (drdy_i) begin
               state_d = S_WR1;
               den_d   = 1'b1;
               dwe_d   = 1'b1;
               di_d    = reg1_word(cur_val, dout_i[15:12]);
            end
         end
         S_WR1_W: begin
            if (drdy_i) begin
               state_d = S_WR2;
               den_d   = 1'b1;
               dwe_d   = 1'b1;
               daddr_d = reg1_addr(set_q) + 7'd1;
               di_d    = reg2_word(cur_val);
            end
         end
         S_WR2_W: begin
            if (drdy_i) begin
               if (set_q == LAST_SET) begin
                  state_d = S_POST;
               end else begin
                  state_d = S_RD;
                  set_d   = set_q + 3'd1;
                  den_d   = 1'b1;
                  daddr_d = reg1_addr(set_q + 3'd1);
               end
            end
         end
         S_POST: begin
            if (cnt_q == HOLD_LAST) begin
               state_d    = S_RELEASE;
               mmcm_rst_d = 1'b0;
            end
         end
         default: state_d = S_HOLD;
      endcase

      // DRP handshake timeout: abandon the remaining registers and leave
      // the MMCM held in reset, since its configuration is now partial.
      if ((state_q == S_RD_W || state_q == S_WR1_W || state_q == S_WR2_W) &&
          !drdy_i && cnt_q == DRP_LAST) begin
         state_d    = S_IDLE;
         err_d      = 1'b1;
         done_d     = 1'b1;
         busy_d     = 1'b0;
         mmcm_rst_d = 1'b1;
      end

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign daddr_o    = daddr_q;
   assign di_o       = di_q;
   assign den_o      = den_q;
   assign dwe_o      = dwe_q;
   assign mmcm_rst_o = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// ---------------------------------------------------------------------------
// tb_mmcm_drp_reconfig
// Scoreboard bench: stimulus pushes the expected DRP accesses and done
// results into a queue, a monitor pops and compares on every den/done.
// A DRP responder and an MMCM lock model drive dout/drdy/locked.
// ---------------------------------------------------------------------------
module tb_mmcm_drp_reconfig;
   localparam int N_CH         = 2;
   localparam int RST_HOLD     = 4;
   localparam int DRP_TIMEOUT  = 255;
   localparam int LOCK_TIMEOUT = 65535;
   localparam int LOCK_DELAY   = 10;

   logic              clk_i    = 1'b0;
   logic              rst_i    = 1'b0;
   logic              req_i    = 1'b0;
   logic [6:0]        mult_i   = '0;
   logic [7*N_CH-1:0] div_i    = '0;
   logic              busy_o;
   logic              done_o;
   logic              err_o;
   logic [6:0]        daddr_o;
   logic [15:0]       di_o;
   logic [15:0]       dout_i   = 16'hA123;
   logic              den_o;
   logic              dwe_o;
   logic              drdy_i   = 1'b0;
   logic              mmcm_rst_o;
   logic              locked_i = 1'b0;

   mmcm_drp_reconfig #(
      .N_CH(N_CH), .RST_HOLD(RST_HOLD),
      .DRP_TIMEOUT(DRP_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .mult_i(mult_i),
      .div_i(div_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .daddr_o(daddr_o), .di_o(di_o), .dout_i(dout_i), .den_o(den_o),
      .dwe_o(dwe_o), .drdy_i(drdy_i), .mmcm_rst_o(mmcm_rst_o),
      .locked_i(locked_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          is_done;
      bit          we;
      logic [6:0]  addr;
      logic [15:0] data;
      bit          err;
      bit          mrst;
      int          from_den;   // expected done cycle minus last den cycle, -1 = skip
      int          from_fall;  // expected done cycle minus mmcm_rst fall, -1 = skip
      int          abs_cyc;    // expected absolute done cycle, -1 = skip
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   acc_cnt = 0;
   int   exp_done = 0;
   int   last_den = 0;
   int   fall_cyc = 0;
   bit   withhold_all = 1'b0;
   bit   withhold_wr = 1'b0;
   bit   lock_hold = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_acc(input bit we, input logic [6:0] addr, input logic [15:0] data);
      exp_t e;
      e = '{is_done: 1'b0, we: we, addr: addr, data: data, err: 1'b0, mrst: 1'b0,
            from_den: -1, from_fall: -1, abs_cyc: -1};
      sb.push_back(e);
   endtask

   task automatic push_done(input bit err, input bit mrst, input int from_den,
                            input int from_fall, input int abs_cyc);
      exp_t e;
      e = '{is_done: 1'b1, we: 1'b0, addr: 7'd0, data: 16'd0, err: err, mrst: mrst,
            from_den: from_den, from_fall: from_fall, abs_cyc: abs_cyc};
      sb.push_back(e);
      exp_done++;
   endtask

   // Cycle counter, read only at falling edges.
   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // DRP responder: drdy one cycle after den, unless withheld.
   initial begin
      bit pend;
      pend = 1'b0;
      forever begin
         @(negedge clk_i);
         drdy_i = pend;
         pend = den_o && !withhold_all && !(dwe_o && withhold_wr);
      end
   end

   // MMCM lock model: locked rises LOCK_DELAY cycles after mmcm_rst falls.
   initial begin
      int lk;
      lk = 0;
      forever begin
         @(negedge clk_i);
         if (mmcm_rst_o) begin
            lk = 0;
            locked_i = 1'b0;
         end else begin
            lk++;
            locked_i = (lk >= LOCK_DELAY) && !lock_hold;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      exp_t e;
      bit   prev_mrst;
      prev_mrst = 1'b1;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            if (prev_mrst && !mmcm_rst_o) fall_cyc = cyc;
            prev_mrst = mmcm_rst_o;
            if (den_o) begin
               acc_cnt++;
               last_den = cyc;
               $display("[%0d] drp %s addr=%02h di=%04h", cyc, dwe_o ? "wr" : "rd", daddr_o, di_o);
               if (sb.size() == 0 || sb[0].is_done) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_den addr=%02h we=%0b required=none", daddr_o, dwe_o);
               end else begin
                  e = sb.pop_front();
                  chk("drp_we", 32'(dwe_o), 32'(e.we));
                  chk("drp_addr", 32'(daddr_o), 32'(e.addr));
                  if (e.we) chk("drp_di", 32'(di_o), 32'(e.data));
               end
            end
            if (done_o) begin
               done_cnt++;
               $display("[%0d] done err=%0b mmcm_rst=%0b busy=%0b", cyc, err_o, mmcm_rst_o, busy_o);
               if (sb.size() == 0 || !sb[0].is_done) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done err=%0b required=none", err_o);
               end else begin
                  e = sb.pop_front();
                  chk("done_err", 32'(err_o), 32'(e.err));
                  chk("done_mmcm_rst", 32'(mmcm_rst_o), 32'(e.mrst));
                  chk("done_busy_low", 32'(busy_o), 32'd0);
                  if (e.from_den >= 0)  chk("done_after_den", 32'(cyc - last_den), 32'(e.from_den));
                  if (e.from_fall >= 0) chk("done_after_rst_fall", 32'(cyc - fall_cyc), 32'(e.from_fall));
                  if (e.abs_cyc >= 0)   chk("done_cycle", 32'(cyc), 32'(e.abs_cyc));
               end
            end
         end
      end
   end

   task automatic wait_done(input int limit, input string name);
      int n;
      n = 0;
      while (done_cnt < exp_done && n < limit) begin
         @(negedge clk_i);
         n++;
      end
      chk(name, (done_cnt >= exp_done) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic issue(input logic [6:0] m, input logic [7*N_CH-1:0] d);
      @(negedge clk_i);
      mult_i = m;
      div_i  = d;
      req_i  = 1'b1;
      @(negedge clk_i);
      req_i  = 1'b0;
      chk("busy_after_req", 32'(busy_o), 32'd1);
      chk("err_clear_on_accept", 32'(err_o), 32'd0);
   endtask

   task automatic powerup();
      int n;
      rst_i = 1'b1;
      #1;
      chk("rst_mmcm_rst", 32'(mmcm_rst_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd1);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_den", 32'(den_o), 32'd0);
      chk("rst_dwe", 32'(dwe_o), 32'd0);
      chk("rst_daddr", 32'(daddr_o), 32'd0);
      chk("rst_di", 32'(di_o), 32'd0);
      push_done(1'b0, 1'b0, -1, LOCK_DELAY, -1);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      n = 0;
      while (mmcm_rst_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk("powerup_rst_cycles", 32'(n), 32'(RST_HOLD));
      wait_done(100, "powerup_done_seen");
      @(negedge clk_i);
      chk("powerup_busy", 32'(busy_o), 32'd0);
      chk("powerup_err", 32'(err_o), 32'd0);
   endtask

   initial begin
      int c;
      int n;
      int base;
      #2;
      // 1. Power-up: no DRP traffic, reset released after RST_HOLD cycles.
      powerup();

      // 2. Even divide 20 on feedback and both channels.
      push_acc(1'b0, 7'h14, 16'h0000); push_acc(1'b1, 7'h14, 16'hA28A); push_acc(1'b1, 7'h15, 16'h0000);
      push_acc(1'b0, 7'h08, 16'h0000); push_acc(1'b1, 7'h08, 16'hA28A); push_acc(1'b1, 7'h09, 16'h0000);
      push_acc(1'b0, 7'h0A, 16'h0000); push_acc(1'b1, 7'h0A, 16'hA28A); push_acc(1'b1, 7'h0B, 16'h0000);
      push_done(1'b0, 1'b0, -1, LOCK_DELAY, -1);
      issue(7'd20, {7'd20, 7'd20});
      wait_done(200, "even_done_seen");

      // 3. Odd mult 63, CLKOUT0 = 5, CLKOUT1 = 1; a second request and
      //    changed inputs while busy must have no effect.
      push_acc(1'b0, 7'h14, 16'h0000); push_acc(1'b1, 7'h14, 16'hA7E0); push_acc(1'b1, 7'h15, 16'h0080);
      push_acc(1'b0, 7'h08, 16'h0000); push_acc(1'b1, 7'h08, 16'hA083); push_acc(1'b1, 7'h09, 16'h0080);
      push_acc(1'b0, 7'h0A, 16'h0000); push_acc(1'b1, 7'h0A, 16'hA001); push_acc(1'b1, 7'h0B, 16'h00C0);
      push_done(1'b0, 1'b0, -1, LOCK_DELAY, -1);
      issue(7'd63, {7'd1, 7'd5});
      repeat (5) @(negedge clk_i);
      mult_i = 7'd0;
      div_i  = '0;
      req_i  = 1'b1;
      @(negedge clk_i);
      req_i  = 1'b0;
      wait_done(200, "odd_done_seen");

      // 4a. Invalid divide 0, req held through the done cycle.
      @(negedge clk_i);
      mult_i = 7'd20;
      div_i  = {7'd5, 7'd0};
      req_i  = 1'b1;
      c = cyc;
      push_done(1'b1, 1'b0, -1, -1, c + 2);
      @(negedge clk_i);
      chk("inv_busy_after_req", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      @(negedge clk_i);
      req_i = 1'b0;
      repeat (10) @(negedge clk_i);
      chk("req_at_done_dropped", 32'(done_cnt), 32'(exp_done));
      chk("inv_idle_busy", 32'(busy_o), 32'd0);
      chk("inv_err_held", 32'(err_o), 32'd1);

      // 4b. Invalid multiplier 127.
      @(negedge clk_i);
      mult_i = 7'd127;
      div_i  = {7'd5, 7'd5};
      req_i  = 1'b1;
      c = cyc;
      push_done(1'b1, 1'b0, -1, -1, c + 2);
      @(negedge clk_i);
      req_i = 1'b0;
      wait_done(20, "inv127_done_seen");

      // 5. DRP timeout: drdy never returned for the first read.
      withhold_all = 1'b1;
      push_acc(1'b0, 7'h14, 16'h0000);
      push_done(1'b1, 1'b1, 1 + DRP_TIMEOUT, -1, -1);
      issue(7'd20, {7'd20, 7'd20});
      wait_done(400, "drp_timeout_done_seen");
      withhold_all = 1'b0;
      repeat (5) @(negedge clk_i);
      chk("drp_timeout_err_held", 32'(err_o), 32'd1);
      chk("drp_timeout_mmcm_rst", 32'(mmcm_rst_o), 32'd1);

      // 6. Lock timeout: locked never rises.
      lock_hold = 1'b1;
      push_acc(1'b0, 7'h14, 16'h0000); push_acc(1'b1, 7'h14, 16'hA28A); push_acc(1'b1, 7'h15, 16'h0000);
      push_acc(1'b0, 7'h08, 16'h0000); push_acc(1'b1, 7'h08, 16'hA28A); push_acc(1'b1, 7'h09, 16'h0000);
      push_acc(1'b0, 7'h0A, 16'h0000); push_acc(1'b1, 7'h0A, 16'hA28A); push_acc(1'b1, 7'h0B, 16'h0000);
      push_done(1'b1, 1'b0, -1, 1 + LOCK_TIMEOUT, -1);
      issue(7'd20, {7'd20, 7'd20});
      wait_done(LOCK_TIMEOUT + 300, "lock_timeout_done_seen");
      lock_hold = 1'b0;

      // 7. Reset while waiting on the first reg1 write.
      withhold_wr = 1'b1;
      base = acc_cnt;
      push_acc(1'b0, 7'h14, 16'h0000); push_acc(1'b1, 7'h14, 16'hA28A);
      issue(7'd20, {7'd20, 7'd20});
      n = 0;
      while (acc_cnt < base + 2 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("wr1_reached", (acc_cnt >= base + 2) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(negedge clk_i);
      withhold_wr = 1'b0;
      powerup();

      repeat (10) @(negedge clk_i);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
